final_state_mc: RTL and testbench

- Multi-channel, parametrised completion/idle status block at the tail of the read/write datapath.
- Per channel: delays each channel's done strobe by a configurable number of cycles.
- Across channels: collects per-channel completions into a sticky set and emits a single all-done pulse plus a wrapping completion counter.
- Drives an aggregate idle flag with asymmetric timing: it falls immediately on activity and rises only after a programmable quiet period.

---
 rtl/final_state_mc_if.sv | 30 +++
 rtl/final_state_mc.sv | 128 ++++++++++++
 tb/tb_final_state_mc.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/final_state_mc_if.sv
// Bus bundle for final_state_mc: per-channel activity/done inputs and
// aggregate completion/idle status outputs.
interface final_state_mc_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 8
) ();

  logic [NUM_CH-1:0] read_i;
  logic [NUM_CH-1:0] write_i;
  logic [NUM_CH-1:0] idle_i;
  logic [NUM_CH-1:0] done_i;
  logic              clr_i;
  logic [NUM_CH-1:0] done_o;
  logic              all_done_o;
  logic [CNT_W-1:0]  done_cnt_o;
  logic              idle_o;

  // Datapath side drives activity and done strobes, observes status.
  modport master (
    output read_i, write_i, idle_i, done_i, clr_i,
    input  done_o, all_done_o, done_cnt_o, idle_o
  );

  // Status block side.
  modport slave (
    input  read_i, write_i, idle_i, done_i, clr_i,
    output done_o, all_done_o, done_cnt_o, idle_o
  );

endinterface

// File: rtl/final_state_mc.sv
// Completion/idle status block at the tail of the read/write datapath.
// Delays per-channel done strobes, collects them into a sticky set that
// fires a single all-done pulse plus a wrapping counter, and drives an
// aggregate idle flag that drops instantly on activity but only rises
// after a programmable quiet period.
module final_state_mc #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned DONE_DLY      = 2,
  parameter int unsigned IDLE_RISE_DLY = 2,
  parameter int unsigned CNT_W         = 8
) (
  input logic             clk,
  input logic             rst_n,
  final_state_mc_if.slave bus
);

  localparam int unsigned QW = $clog2(IDLE_RISE_DLY + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  logic [NUM_CH-1:0][DONE_DLY-1:0] r_pipe;
  logic [NUM_CH-1:0][DONE_DLY-1:0] w_pipe_d;
  logic [NUM_CH-1:0]               w_done_o;
  logic [NUM_CH-1:0]               r_seen;
  logic [NUM_CH-1:0]               w_seen_nxt;
  logic                            w_all;
  logic                            r_all_done;
  logic [CNT_W-1:0]                r_cnt;
  logic                            w_act;
  state_e                          r_state;
  state_e                          w_state_d;
  logic [QW-1:0]                   r_quiet;
  logic [QW-1:0]                   w_quiet_d;

  // Shift each channel's done strobe one stage deeper per cycle.
  always_comb begin
    w_pipe_d = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      w_pipe_d[c][0] = bus.done_i[c];
      for (int k = 1; k < int'(DONE_DLY); k++) begin
        w_pipe_d[c][k] = r_pipe[c][k-1];
      end
    end
  end

  // Last pipe stage is the delayed strobe.
  always_comb begin
    w_done_o = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      w_done_o[c] = r_pipe[c][DONE_DLY-1];
    end
  end

  // Sticky completion set; a delayed done landing with clr_i is kept.
  always_comb begin
    w_seen_nxt = (bus.clr_i ? '0 : r_seen) | w_done_o;
    w_all      = (&w_seen_nxt) & ~bus.clr_i;
    w_act      = (|bus.read_i) | (|bus.write_i) | (|w_done_o) | (|(~bus.idle_i));
  end

  // Pipe, sticky set, all-done pulse and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe     <= '0;
      r_seen     <= '0;
      r_all_done <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_pipe     <= w_pipe_d;
      // Emptying the set on the firing cycle keeps one collection to one pulse.
      r_seen     <= w_all ? '0 : w_seen_nxt;
      r_all_done <= w_all;
      r_cnt      <= r_cnt + CNT_W'(w_all);
    end
  end

  // Idle FSM state and quiet-period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_quiet <= '0;
    end else begin
      r_state <= w_state_d;
      r_quiet <= w_quiet_d;
    end
  end

  // Next-state: any activity returns to busy; idle only after a full quiet run.
  always_comb begin
    w_state_d = r_state;
    w_quiet_d = r_quiet;
    unique case (r_state)
      StIdle: begin
        if (w_act) begin
          w_state_d = StBusy;
        end
      end
      StBusy: begin
        if (!w_act) begin
          w_state_d = StDrain;
          w_quiet_d = QW'(1);
        end
      end
      StDrain: begin
        if (w_act) begin
          w_state_d = StBusy;
          w_quiet_d = '0;
        end else if (r_quiet == QW'(IDLE_RISE_DLY)) begin
          w_state_d = StIdle;
          w_quiet_d = '0;
        end else begin
          w_quiet_d = r_quiet + QW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_quiet_d = '0;
      end
    endcase
  end

  assign bus.done_o     = w_done_o;
  assign bus.all_done_o = r_all_done;
  assign bus.done_cnt_o = r_cnt;
  // Activity masks idle combinationally so the fall has zero latency.
  assign bus.idle_o     = (r_state == StIdle) & ~w_act;

endmodule

// File: tb/tb_final_state_mc.sv
// Bench for final_state_mc: table-driven vectors plus a cycle-level
// reference model feeding a scoreboard queue.
module tb_final_state_mc;

  localparam int unsigned IRD = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  final_state_mc_if #(.NUM_CH(2), .CNT_W(8)) bus ();
  final_state_mc_if #(.NUM_CH(2), .CNT_W(2)) bus2 ();

  assign bus2.read_i  = bus.read_i;
  assign bus2.write_i = bus.write_i;
  assign bus2.idle_i  = bus.idle_i;
  assign bus2.done_i  = bus.done_i;
  assign bus2.clr_i   = bus.clr_i;

  final_state_mc #(
    .NUM_CH(2), .DONE_DLY(2), .IDLE_RISE_DLY(IRD), .CNT_W(8)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  final_state_mc #(
    .NUM_CH(2), .DONE_DLY(2), .IDLE_RISE_DLY(IRD), .CNT_W(2)
  ) u_dut_w2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  typedef struct {
    logic [1:0] rd;
    logic [1:0] wr;
    logic [1:0] idl;
    logic [1:0] dn;
    logic       clr;
    logic [1:0] e_done;
    logic       e_ad;
    logic [7:0] e_cnt;
    logic       e_idle;
  } vec_t;

  typedef struct {
    logic [1:0] done;
    logic       ad;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic       idle;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[13];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [1:0] m_p0, m_p1, m_seen;
  logic       m_ad;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;
  int         m_qe;
  bit         in_rst;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_p0 = '0; m_p1 = '0; m_seen = '0; m_ad = 1'b0;
    m_cnt = '0; m_cnt2 = '0; m_qe = IRD + 1;
  endtask

  function automatic vec_t mk(input logic [1:0] dn, input logic clr, input logic [1:0] rd,
                              input logic [1:0] wr, input logic [1:0] idl);
    vec_t v;
    v.dn = dn; v.clr = clr; v.rd = rd; v.wr = wr; v.idl = idl;
    v.e_done = '0; v.e_ad = 1'b0; v.e_cnt = '0; v.e_idle = 1'b0;
    return v;
  endfunction

  function automatic vec_t mkt(input logic [1:0] dn, input logic [1:0] e_done, input logic e_ad,
                               input logic [7:0] e_cnt, input logic e_idle);
    vec_t v;
    v = mk(dn, 1'b0, 2'b00, 2'b00, 2'b11);
    v.e_done = e_done; v.e_ad = e_ad; v.e_cnt = e_cnt; v.e_idle = e_idle;
    return v;
  endfunction

  // Called just after a rising edge: drive, predict, check mid-cycle, advance model.
  task automatic step(input vec_t v, input bit use_tbl);
    exp_t       e, g;
    logic       act;
    logic [1:0] nxt;
    logic       all;
    bus.read_i  = v.rd;
    bus.write_i = v.wr;
    bus.idle_i  = v.idl;
    bus.done_i  = v.dn;
    bus.clr_i   = v.clr;
    act    = (|v.rd) | (|v.wr) | (|m_p1) | (|(~v.idl));
    e.done = m_p1;
    e.ad   = m_ad;
    e.cnt  = m_cnt;
    e.cnt2 = m_cnt2;
    e.idle = !act && (m_qe >= IRD + 1);
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      g = sb_q.pop_front();
      chk("done_o", 32'(bus.done_o), 32'(g.done));
      chk("all_done_o", 32'(bus.all_done_o), 32'(g.ad));
      chk("done_cnt_o", 32'(bus.done_cnt_o), 32'(g.cnt));
      chk("idle_o", 32'(bus.idle_o), 32'(g.idle));
      chk("done_cnt_o_w2", 32'(bus2.done_cnt_o), 32'(g.cnt2));
    end
    if (use_tbl) begin
      chk("tbl_done_o", 32'(bus.done_o), 32'(v.e_done));
      chk("tbl_all_done_o", 32'(bus.all_done_o), 32'(v.e_ad));
      chk("tbl_done_cnt_o", 32'(bus.done_cnt_o), 32'(v.e_cnt));
      chk("tbl_idle_o", 32'(bus.idle_o), 32'(v.e_idle));
    end
    @(posedge clk);
    if (in_rst) begin
      model_reset();
    end else begin
      nxt    = (v.clr ? 2'b00 : m_seen) | m_p1;
      all    = (nxt == 2'b11) && !v.clr;
      m_seen = all ? 2'b00 : nxt;
      m_ad   = all;
      m_cnt  = m_cnt + 8'(all);
      m_cnt2 = m_cnt2 + 2'(all);
      if (act) m_qe = 0;
      else if (m_qe < IRD + 1) m_qe = m_qe + 1;
      m_p1 = m_p0;
      m_p0 = v.dn;
    end
    #1;
  endtask

  task automatic s(input logic [1:0] dn, input logic clr, input logic [1:0] rd,
                   input logic [1:0] wr, input logic [1:0] idl);
    step(mk(dn, clr, rd, wr, idl), 1'b0);
  endtask

  task automatic q(input int n);
    for (int i = 0; i < n; i++) s(2'b00, 1'b0, 2'b00, 2'b00, 2'b11);
  endtask

  // Hold reset across one full cycle with quiet inputs, checking reset values.
  task automatic rst_step();
    rst_n  = 1'b0;
    in_rst = 1'b1;
    #1;
    model_reset();
    s(2'b00, 1'b0, 2'b00, 2'b00, 2'b11);
    in_rst = 1'b0;
    rst_n  = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_rst      = 1'b1;
    bus.read_i  = '0;
    bus.write_i = '0;
    bus.idle_i  = 2'b11;
    bus.done_i  = '0;
    bus.clr_i   = 1'b0;
    model_reset();

    tbl[0]  = mkt(2'b00, 2'b00, 1'b0, 8'd0, 1'b1);
    tbl[1]  = mkt(2'b01, 2'b00, 1'b0, 8'd0, 1'b1);
    tbl[2]  = mkt(2'b00, 2'b00, 1'b0, 8'd0, 1'b1);
    tbl[3]  = mkt(2'b00, 2'b01, 1'b0, 8'd0, 1'b0);
    tbl[4]  = mkt(2'b00, 2'b00, 1'b0, 8'd0, 1'b0);
    tbl[5]  = mkt(2'b10, 2'b00, 1'b0, 8'd0, 1'b0);
    tbl[6]  = mkt(2'b00, 2'b00, 1'b0, 8'd0, 1'b0);
    tbl[7]  = mkt(2'b00, 2'b10, 1'b0, 8'd0, 1'b0);
    tbl[8]  = mkt(2'b00, 2'b00, 1'b1, 8'd1, 1'b0);
    tbl[9]  = mkt(2'b00, 2'b00, 1'b0, 8'd1, 1'b0);
    tbl[10] = mkt(2'b00, 2'b00, 1'b0, 8'd1, 1'b0);
    tbl[11] = mkt(2'b00, 2'b00, 1'b0, 8'd1, 1'b1);
    tbl[12] = mkt(2'b00, 2'b00, 1'b0, 8'd1, 1'b1);

    @(posedge clk);
    #1;
    rst_step();
    q(4);

    // Single-channel delay, all-done pulse and idle timing.
    for (int i = 0; i < 13; i++) step(tbl[i], 1'b1);

    // Second collection in the same cycle on both channels.
    s(2'b11, 1'b0, 2'b00, 2'b00, 2'b11);
    q(6);

    // Clear racing a delayed done: the done survives the clear.
    s(2'b01, 1'b0, 2'b00, 2'b00, 2'b11);
    s(2'b00, 1'b0, 2'b00, 2'b00, 2'b11);
    s(2'b10, 1'b0, 2'b00, 2'b00, 2'b11);
    s(2'b00, 1'b0, 2'b00, 2'b00, 2'b11);
    s(2'b00, 1'b1, 2'b00, 2'b00, 2'b11);
    q(2);
    // Channel 0 now completes the set left at 10.
    s(2'b01, 1'b0, 2'b00, 2'b00, 2'b11);
    q(5);
    // Clear alone empties the set, so channel 1 alone must not fire.
    s(2'b01, 1'b0, 2'b00, 2'b00, 2'b11);
    q(3);
    s(2'b00, 1'b1, 2'b00, 2'b00, 2'b11);
    s(2'b10, 1'b0, 2'b00, 2'b00, 2'b11);
    q(5);
    s(2'b00, 1'b1, 2'b00, 2'b00, 2'b11);
    q(1);

    // Idle timing: read burst, then read burst extended by a write pulse.
    for (int i = 0; i < 5; i++) s(2'b00, 1'b0, 2'b10, 2'b00, 2'b11);
    q(5);
    for (int i = 0; i < 5; i++) s(2'b00, 1'b0, 2'b10, 2'b00, 2'b11);
    s(2'b00, 1'b0, 2'b00, 2'b01, 2'b11);
    q(5);
    // Write after one quiet cycle restarts the quiet period from drain.
    s(2'b00, 1'b0, 2'b01, 2'b00, 2'b11);
    s(2'b00, 1'b0, 2'b00, 2'b00, 2'b11);
    s(2'b00, 1'b0, 2'b00, 2'b10, 2'b11);
    q(5);
    // Engine busy via idle_i.
    s(2'b00, 1'b0, 2'b00, 2'b00, 2'b01);
    s(2'b00, 1'b0, 2'b00, 2'b00, 2'b10);
    q(5);

    // Counter wrap on the 2-bit instance: 1,2,3,0,1.
    rst_step();
    for (int k = 0; k < 5; k++) begin
      s(2'b11, 1'b0, 2'b00, 2'b00, 2'b11);
      q(3);
    end

    // Mid-operation reset with strobes in the pipe.
    s(2'b11, 1'b0, 2'b00, 2'b00, 2'b11);
    s(2'b01, 1'b0, 2'b00, 2'b00, 2'b11);
    rst_step();
    q(6);

    // Randomised sparse traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic [1:0] dn, rd, wr, idl;
      logic       clr;
      dn  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      clr = ($urandom_range(0, 15) == 0);
      rd  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      wr  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      idl = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      s(dn, clr, rd, wr, idl);
    end
    q(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
